// File: rtl/in_service_tracker.sv
// In-service register for the interrupt controller: tracks acknowledged levels, population count,
// rotation-aware highest level in service and a sticky protocol error. Optional auto-EOI: ISR_AUTO_EOI_EN.
module in_service_tracker #(
  parameter int NUM_IR = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_initial_command_word_1,
  input  logic [NUM_IR-1:0] interrupt,
  input  logic              latch_in_service,
  input  logic [NUM_IR-1:0] end_of_interrupt,
  input  logic [2:0]        priority_rotate,
`ifdef ISR_AUTO_EOI_EN
  input  logic              auto_eoi_mode,
  input  logic              end_of_acknowledge_sequence,
`endif
  output logic [NUM_IR-1:0] in_service_register,
  output logic [NUM_IR-1:0] highest_level_in_service,
  output logic [CNT_W-1:0]  in_service_count,
  output logic              protocol_error
);

  logic [NUM_IR-1:0] isr_q, isr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              error_q, error_d;
  logic [NUM_IR-1:0] set_vec;
  logic [NUM_IR-1:0] clear_mask;
  logic              is_one_hot;
  logic              multi_hot;
  logic              relatch;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_IR-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_IR; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  assign is_one_hot = (interrupt != '0) && ((interrupt & (interrupt - 1'b1)) == '0);
  assign multi_hot  = (interrupt != '0) && !is_one_hot;
  assign set_vec    = (latch_in_service && is_one_hot) ? interrupt : '0;

`ifdef ISR_AUTO_EOI_EN
  logic [NUM_IR-1:0] last_ack_q, last_ack_d;
  logic              auto_clear;

  assign auto_clear = end_of_acknowledge_sequence && auto_eoi_mode;
  assign clear_mask = end_of_interrupt | (auto_clear ? last_ack_q : '0);

  // A new acknowledge replaces the pending auto-EOI target even when both happen together.
  always_comb begin
    last_ack_d = last_ack_q;
    if (set_vec != '0)   last_ack_d = set_vec;
    else if (auto_clear) last_ack_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset || write_initial_command_word_1) last_ack_q <= '0;
    else                                       last_ack_q <= last_ack_d;
  end
`else
  assign clear_mask = end_of_interrupt;
`endif

  assign relatch = (set_vec & isr_q & ~clear_mask) != '0;

  always_comb begin
    isr_d   = (isr_q & ~clear_mask) | set_vec;
    count_d = popcount(isr_d);
    error_d = error_q;
    if (latch_in_service && (multi_hot || relatch)) error_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || write_initial_command_word_1) begin
      isr_q   <= '0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      isr_q   <= isr_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  // Rotate so the highest-priority level sits at bit 0, keep the lowest set bit, rotate back.
  logic [2:0]          rot_amt;
  logic [2*NUM_IR-1:0] right_dbl;
  logic [2*NUM_IR-1:0] left_dbl;
  logic [NUM_IR-1:0]   rotated;
  logic [NUM_IR-1:0]   lowest;

  always_comb begin
    rot_amt   = priority_rotate + 3'd1;
    right_dbl = {isr_q, isr_q} >> rot_amt;
    rotated   = right_dbl[NUM_IR-1:0];
    lowest    = rotated & (~rotated + 1'b1);
    left_dbl  = {lowest, lowest} << rot_amt;
  end

  assign highest_level_in_service = left_dbl[2*NUM_IR-1:NUM_IR];
  assign in_service_register      = isr_q;
  assign in_service_count         = count_q;
  assign protocol_error           = error_q;

endmodule

// File: tb/tb_in_service_tracker.sv
// Directed, table-driven bench for in_service_tracker plus hand-written combinational/auto-EOI sequences.
module tb_in_service_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic       icw1;
  logic [7:0] interrupt;
  logic       latch;
  logic [7:0] eoi;
  logic [2:0] rotate;
  logic [7:0] isr;
  logic [7:0] highest;
  logic [3:0] count;
  logic       perr;
`ifdef ISR_AUTO_EOI_EN
  logic       autoMode;
  logic       eoas;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  in_service_tracker dut (
    .clk                          (clk),
    .reset                        (reset),
    .write_initial_command_word_1 (icw1),
    .interrupt                    (interrupt),
    .latch_in_service             (latch),
    .end_of_interrupt             (eoi),
    .priority_rotate              (rotate),
`ifdef ISR_AUTO_EOI_EN
    .auto_eoi_mode                (autoMode),
    .end_of_acknowledge_sequence  (eoas),
`endif
    .in_service_register          (isr),
    .highest_level_in_service     (highest),
    .in_service_count             (count),
    .protocol_error               (perr)
  );

  typedef struct {
    logic       rst;
    logic       icw;
    logic       lat;
    logic [7:0] irq;
    logic [7:0] eoiMask;
    logic [2:0] rot;
    logic [7:0] expIsr;
    logic [3:0] expCnt;
    logic [7:0] expHi;
    logic       expErr;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic rst, input logic icw, input logic lat, input logic [7:0] irq,
                        input logic [7:0] em, input logic [2:0] rot, input logic [7:0] ei,
                        input logic [3:0] ec, input logic [7:0] eh, input logic ee);
    vec_t v;
    v.rst = rst; v.icw = icw; v.lat = lat; v.irq = irq; v.eoiMask = em; v.rot = rot;
    v.expIsr = ei; v.expCnt = ec; v.expHi = eh; v.expErr = ee;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic rst, input logic icw, input logic lat,
                               input logic [7:0] irq, input logic [7:0] em, input logic [2:0] rot);
    @(negedge clk);
    reset = rst; icw1 = icw; latch = lat; interrupt = irq; eoi = em; rotate = rot;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] ei, input logic [3:0] ec,
                             input logic [7:0] eh, input logic ee);
    checks += 4;
    if (isr !== ei) begin
      failures++;
      $display("[TB] FAIL %s isr got=%h want=%h", name, isr, ei);
    end
    if (count !== ec) begin
      failures++;
      $display("[TB] FAIL %s count got=%0d want=%0d", name, count, ec);
    end
    if (highest !== eh) begin
      failures++;
      $display("[TB] FAIL %s highest got=%h want=%h", name, highest, eh);
    end
    if (perr !== ee) begin
      failures++;
      $display("[TB] FAIL %s perr got=%b want=%b", name, perr, ee);
    end
  endtask

  initial begin
    reset = 1'b1; icw1 = 1'b0; latch = 1'b0; interrupt = '0; eoi = '0; rotate = 3'd7;
`ifdef ISR_AUTO_EOI_EN
    autoMode = 1'b0; eoas = 1'b0;
`endif

    //     rst icw lat irq    eoi    rot   isr    cnt hi     err
    addVec(1, 0, 0, 8'h00, 8'h00, 3'd7, 8'h00, 0, 8'h00, 0);
    addVec(0, 0, 0, 8'h00, 8'h00, 3'd7, 8'h00, 0, 8'h00, 0);
    addVec(0, 0, 1, 8'h08, 8'h00, 3'd7, 8'h08, 1, 8'h08, 0);
    addVec(0, 0, 1, 8'h02, 8'h00, 3'd7, 8'h0A, 2, 8'h02, 0);
    addVec(0, 0, 0, 8'h00, 8'h02, 3'd7, 8'h08, 1, 8'h08, 0);
    addVec(0, 0, 0, 8'h00, 8'h08, 3'd7, 8'h00, 0, 8'h00, 0);
    addVec(0, 0, 1, 8'h01, 8'h00, 3'd7, 8'h01, 1, 8'h01, 0);
    addVec(0, 0, 1, 8'h80, 8'h00, 3'd7, 8'h81, 2, 8'h01, 0);
    addVec(0, 0, 0, 8'h00, 8'h00, 3'd6, 8'h81, 2, 8'h80, 0);
    addVec(0, 0, 0, 8'h00, 8'h00, 3'd7, 8'h81, 2, 8'h01, 0);
    addVec(0, 0, 0, 8'h00, 8'hFF, 3'd7, 8'h00, 0, 8'h00, 0);
    addVec(0, 0, 1, 8'h10, 8'h00, 3'd7, 8'h10, 1, 8'h10, 0);
    addVec(0, 0, 1, 8'h10, 8'h10, 3'd7, 8'h10, 1, 8'h10, 0);
    addVec(0, 0, 1, 8'h10, 8'h00, 3'd7, 8'h10, 1, 8'h10, 1);
    addVec(0, 0, 1, 8'h05, 8'h00, 3'd7, 8'h10, 1, 8'h10, 1);
    addVec(0, 0, 1, 8'h00, 8'h00, 3'd7, 8'h10, 1, 8'h10, 1);
    addVec(0, 0, 0, 8'h00, 8'h04, 3'd7, 8'h10, 1, 8'h10, 1);
    addVec(0, 1, 0, 8'h00, 8'h00, 3'd7, 8'h00, 0, 8'h00, 0);
    addVec(0, 0, 1, 8'h01, 8'h00, 3'd7, 8'h01, 1, 8'h01, 0);
    addVec(0, 0, 1, 8'h02, 8'h00, 3'd7, 8'h03, 2, 8'h01, 0);
    addVec(0, 0, 1, 8'h04, 8'h00, 3'd7, 8'h07, 3, 8'h01, 0);
    addVec(0, 0, 1, 8'h08, 8'h00, 3'd7, 8'h0F, 4, 8'h01, 0);
    addVec(0, 0, 1, 8'h10, 8'h00, 3'd7, 8'h1F, 5, 8'h01, 0);
    addVec(0, 0, 1, 8'h20, 8'h00, 3'd7, 8'h3F, 6, 8'h01, 0);
    addVec(0, 0, 1, 8'h40, 8'h00, 3'd7, 8'h7F, 7, 8'h01, 0);
    addVec(0, 0, 1, 8'h80, 8'h00, 3'd7, 8'hFF, 8, 8'h01, 0);
    addVec(0, 1, 1, 8'h01, 8'h00, 3'd7, 8'h00, 0, 8'h00, 0);
    addVec(0, 0, 1, 8'h20, 8'h00, 3'd2, 8'h20, 1, 8'h20, 0);
    addVec(0, 0, 1, 8'h08, 8'h00, 3'd2, 8'h28, 2, 8'h08, 0);
    addVec(0, 0, 0, 8'h00, 8'h00, 3'd4, 8'h28, 2, 8'h20, 0);
    addVec(0, 0, 1, 8'h06, 8'h20, 3'd4, 8'h08, 1, 8'h08, 1);
    addVec(1, 0, 1, 8'h01, 8'h00, 3'd7, 8'h00, 0, 8'h00, 0);
    addVec(0, 0, 1, 8'h40, 8'h40, 3'd7, 8'h40, 1, 8'h40, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].icw, vecs[i].lat, vecs[i].irq, vecs[i].eoiMask, vecs[i].rot);
      checkOutput($sformatf("vec%0d", i), vecs[i].expIsr, vecs[i].expCnt, vecs[i].expHi, vecs[i].expErr);
    end

    // Rotation changes must reach highest_level_in_service without a clock edge.
    applyStimulus(0, 0, 1, 8'h01, 8'h00, 3'd7);
    checkOutput("build41", 8'h41, 2, 8'h01, 0);
    @(negedge clk);
    latch = 1'b0; interrupt = '0; rotate = 3'd0;
    #1;
    checkOutput("combRot0", 8'h41, 2, 8'h40, 0);
    rotate = 3'd5;
    #1;
    checkOutput("combRot5", 8'h41, 2, 8'h40, 0);
    rotate = 3'd6;
    #1;
    checkOutput("combRot6", 8'h41, 2, 8'h01, 0);

`ifdef ISR_AUTO_EOI_EN
    applyStimulus(0, 1, 0, 8'h00, 8'h00, 3'd7);
    autoMode = 1'b1;
    applyStimulus(0, 0, 1, 8'h04, 8'h00, 3'd7);
    checkOutput("aeoiLatch", 8'h04, 1, 8'h04, 0);
    @(negedge clk);
    latch = 1'b0; interrupt = '0; eoas = 1'b1;
    @(posedge clk); #1;
    checkOutput("aeoiClear", 8'h00, 0, 8'h00, 0);
    @(negedge clk);
    eoas = 1'b0;
    applyStimulus(0, 0, 1, 8'h04, 8'h00, 3'd7);
    @(negedge clk);
    latch = 1'b1; interrupt = 8'h02; eoas = 1'b1;
    @(posedge clk); #1;
    checkOutput("aeoiSameCycle", 8'h02, 1, 8'h02, 0);
    @(negedge clk);
    latch = 1'b0; interrupt = '0;
    @(posedge clk); #1;
    checkOutput("aeoiNewTarget", 8'h00, 0, 8'h00, 0);
    @(negedge clk);
    eoas = 1'b0; autoMode = 1'b0;
    applyStimulus(0, 0, 1, 8'h04, 8'h00, 3'd7);
    @(negedge clk);
    latch = 1'b0; interrupt = '0; eoas = 1'b1;
    @(posedge clk); #1;
    checkOutput("aeoiDisabled", 8'h04, 1, 8'h04, 0);
    @(negedge clk);
    eoas = 1'b0;
    applyStimulus(0, 0, 0, 8'h00, 8'h04, 3'd7);
    checkOutput("aeoiManualEoi", 8'h00, 0, 8'h00, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
